// File: rtl/mux2_demux4.sv
// Registered 2:1 mux and 1:4 demux steering stage with one clock and a synchronous active-high reset.
// Optional clock enable port `ce` is present when MUX_DEMUX_CE_EN is defined.
module mux2_demux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MUX_DEMUX_CE_EN
  input  logic                 ce,
`endif
  input  logic [2*WIDTH-1:0]   mux_i,
  input  logic                 mux_sel,
  output logic [WIDTH-1:0]     mux_y,
  input  logic [WIDTH-1:0]     demux_i,
  input  logic [1:0]           demux_sel,
  output logic [4*WIDTH-1:0]   demux_y
);

  logic [WIDTH-1:0]   mux_d, mux_q;
  logic [4*WIDTH-1:0] demux_d, demux_q;
  logic               upd;

`ifdef MUX_DEMUX_CE_EN
  assign upd = ce;
`else
  assign upd = 1'b1;
`endif

  always_comb begin
    mux_d = mux_sel ? mux_i[2*WIDTH-1:WIDTH] : mux_i[WIDTH-1:0];
  end

  // Unselected lanes clear rather than hold.
  always_comb begin
    demux_d = '0;
    unique case (demux_sel)
      2'd0: demux_d[0*WIDTH +: WIDTH] = demux_i;
      2'd1: demux_d[1*WIDTH +: WIDTH] = demux_i;
      2'd2: demux_d[2*WIDTH +: WIDTH] = demux_i;
      2'd3: demux_d[3*WIDTH +: WIDTH] = demux_i;
      default: demux_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_q   <= '0;
      demux_q <= '0;
    end else if (upd) begin
      mux_q   <= mux_d;
      demux_q <= demux_d;
    end
  end

  assign mux_y   = mux_q;
  assign demux_y = demux_q;

endmodule

// File: tb/tb_mux2_demux4.sv
// Scoreboard bench for mux2_demux4 (WIDTH=1): stimulus pushes hand-computed expectations,
// a monitor pops and compares one edge later. Clock-enable vectors run only with MUX_DEMUX_CE_EN.
module tb_mux2_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [1:0] mux_i;
  logic       mux_sel;
  logic       mux_y;
  logic       demux_i;
  logic [1:0] demux_sel;
  logic [3:0] demux_y;

  int tests_run = 0;
  int tests_failed = 0;
  bit stim_done = 1'b0;

  logic [4:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  mux2_demux4 #(
    .WIDTH(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MUX_DEMUX_CE_EN
    .ce       (ce),
`endif
    .mux_i    (mux_i),
    .mux_sel  (mux_sel),
    .mux_y    (mux_y),
    .demux_i  (demux_i),
    .demux_sel(demux_sel),
    .demux_y  (demux_y)
  );

  // Drive on the falling edge; the expectation belongs to the next rising edge.
  task automatic step(input string nm, input logic r, input logic c, input logic [1:0] mi,
                      input logic ms, input logic di, input logic [1:0] ds,
                      input logic em, input logic [3:0] ed);
    @(negedge clk);
    rst       = r;
    ce        = c;
    mux_i     = mi;
    mux_sel   = ms;
    demux_i   = di;
    demux_sel = ds;
    exp_q.push_back({em, ed});
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are registered, so compare just after each rising edge.
  initial begin
    logic [4:0] e;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        tests_run++;
        if ({mux_y, demux_y} !== e) begin
          tests_failed++;
          $display("FAIL %s: got mux_y=%b demux_y=%b, expected mux_y=%b demux_y=%b",
                   n, mux_y, demux_y, e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    //    name            rst ce mux_i  msel di ds     mux demux
    step("reset0",        1, 1, 2'b11, 1'b0, 1, 2'd0, 0, 4'b0000);
    step("reset1",        1, 1, 2'b11, 1'b1, 1, 2'd1, 0, 4'b0000);
    step("mux_lane0_a",   0, 1, 2'b01, 1'b0, 0, 2'd0, 1, 4'b0000);
    step("mux_lane0_b",   0, 1, 2'b10, 1'b0, 0, 2'd0, 0, 4'b0000);
    step("mux_lane1_a",   0, 1, 2'b10, 1'b1, 0, 2'd0, 1, 4'b0000);
    step("mux_lane1_tg1", 0, 1, 2'b11, 1'b1, 0, 2'd0, 1, 4'b0000);
    step("mux_lane1_tg0", 0, 1, 2'b10, 1'b1, 0, 2'd0, 1, 4'b0000);
    step("mux_lane1_lo",  0, 1, 2'b01, 1'b1, 0, 2'd0, 0, 4'b0000);
    step("mux_sel_data",  0, 1, 2'b01, 1'b0, 0, 2'd0, 1, 4'b0000);
    step("demux_sel0",    0, 1, 2'b01, 1'b0, 1, 2'd0, 1, 4'b0001);
    step("demux_sel1",    0, 1, 2'b01, 1'b0, 1, 2'd1, 1, 4'b0010);
    step("demux_sel2",    0, 1, 2'b00, 1'b0, 1, 2'd2, 0, 4'b0100);
    step("demux_sel3",    0, 1, 2'b00, 1'b0, 1, 2'd3, 0, 4'b1000);
    step("demux_sel2_d0", 0, 1, 2'b00, 1'b0, 0, 2'd2, 0, 4'b0000);
    step("midrun_load",   0, 1, 2'b10, 1'b1, 1, 2'd3, 1, 4'b1000);
    step("midrun_rst",    1, 1, 2'b10, 1'b1, 1, 2'd3, 0, 4'b0000);
    step("midrun_rel",    0, 1, 2'b10, 1'b1, 1, 2'd3, 1, 4'b1000);
    step("indep_mux",     0, 1, 2'b01, 1'b0, 1, 2'd3, 1, 4'b1000);
`ifdef MUX_DEMUX_CE_EN
    step("ce_load",       0, 1, 2'b10, 1'b1, 1, 2'd1, 1, 4'b0010);
    step("ce_hold",       0, 0, 2'b00, 1'b0, 1, 2'd3, 1, 4'b0010);
    step("ce_rst",        1, 0, 2'b11, 1'b1, 1, 2'd3, 0, 4'b0000);
    step("ce_hold_zero",  0, 0, 2'b10, 1'b1, 1, 2'd2, 0, 4'b0000);
    step("ce_resume",     0, 1, 2'b10, 1'b1, 1, 2'd2, 1, 4'b0100);
`endif
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
